// File: rtl/execute_stage.sv
// RV32I execute stage with EX/MEM pipeline register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (ALUControlE = 1010).
module execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            RegWriteE,
  input  logic [4:0]      RegDestinE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RegDestinM,
  output logic            RegWriteM,
  output logic [XLEN-1:0] PCTargetE,
  output logic            ZeroE,
  output logic            MulBusyE
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b     = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt     = src_b[4:0];
  assign PCTargetE = PCE + ImmExtE;

`ifdef EXEC_MUL_EN
  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  mul_state_e      state_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic            is_mul;

  assign is_mul   = (ALUControlE == 4'b1010);
  assign MulBusyE = ((state_q == IDLE) && is_mul) || (state_q == BUSY);

  // Operands are captured at issue: the M/W forwarding sources keep moving
  // while bubbles drain, so the iteration must not look at them again.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mul) begin
            state_q  <= BUSY;
            mcand_q  <= src_a;
            mplier_q <= src_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYCLES - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign MulBusyE = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      4'b0000: alu_res = src_a + src_b;
      4'b0001: alu_res = src_a - src_b;
      4'b0010: alu_res = src_a & src_b;
      4'b0011: alu_res = src_a | src_b;
      4'b0100: alu_res = src_a ^ src_b;
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b0110: alu_res = src_a << shamt;
      4'b0111: alu_res = src_a >> shamt;
      4'b1000: alu_res = $signed(src_a) >>> shamt;
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef EXEC_MUL_EN
      4'b1010: if (state_q == DONE) alu_res = acc_q;
`endif
      default: alu_res = '0;
    endcase
  end

  assign ZeroE = (alu_res == '0);

  always_ff @(posedge clk) begin
    if (reset || FlushE || MulBusyE) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      RegDestinM <= '0;
      RegWriteM  <= 1'b0;
    end else begin
      ALUResultM <= alu_res;
      WriteDataM <= fwd_b;
      RegDestinM <= RegDestinE;
      RegWriteM  <= RegWriteE;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (E) stage of the five-stage RV32I pipeline, including the EX/MEM pipeline register. It consumes the forwarding selects produced by the hazard unit, picks each ALU operand from the register file, the M-stage result or the W-stage result, and computes the ALU result and branch target. The result is registered into the M stage. An optional iterative multiplier holds the instruction in E for several cycles and raises a stall toward the front end while it runs.

## Interface
Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, iteration count of the shift-add multiplier (must equal XLEN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- FlushE  in  1  discard the instruction in E; insert a bubble into M
- ALUControlE  in  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 mul; other codes produce result 0
- ALUSrcE  in  1  operand B: 0 = forwarded rs2, 1 = ImmExtE
- RegWriteE  in  1  instruction writes rd
- RegDestinE  in  5  rd
- RD1E, RD2E  in  XLEN  register-file read data
- ImmExtE, PCE  in  XLEN  immediate and PC of the E instruction
- ForwardAE, ForwardBE  in  2  operand select: 00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = treated as 00
- ResultW  in  XLEN  W-stage writeback value
- ALUResultM  out  XLEN  registered result (also the forwarding source)
- WriteDataM  out  XLEN  registered forwarded rs2 (store data)
- RegDestinM  out  5  registered rd
- RegWriteM  out  1  registered write enable
- PCTargetE  out  XLEN  PCE + ImmExtE, combinational
- ZeroE  out  1  combinational: ALU result == 0
- MulBusyE  out  1  stall request for the F, D and E registers

## Operation
- Operand A is selected by ForwardAE. Forwarded B is selected by ForwardBE. SrcB = ALUSrcE ? ImmExtE : forwarded B.
- Shift amounts use SrcB[4:0]. slt is signed and sltu is unsigned. add and sub wrap modulo 2^XLEN.
- EX/MEM register, at each rising edge:
  - reset or FlushE: all M outputs are 0.
  - MulBusyE = 1: bubble (RegWriteM = 0, RegDestinM = 0, ALUResultM = 0, WriteDataM = 0).
  - Otherwise: capture the ALU result, forwarded B, RegDestinE and RegWriteE.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - IDLE → BUSY when ALUControlE = 1010 and FlushE = 0. On this transition: latch the forwarded operands (A as multiplicand, SrcB as multiplier), clear the accumulator, and set count = 0.
  - BUSY: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment count. When count = MUL_CYCLES−1, go to DONE.
  - DONE: the ALU result is the low XLEN bits of the accumulator. Return to IDLE at the next edge.
- MulBusyE = (IDLE and ALUControlE = 1010) or BUSY. It is combinational and independent of FlushE.
- Operands are latched at issue because the M and W forwarding sources change while bubbles drain.
- FlushE in any state: FSM returns to IDLE and the product is discarded.
- reset mid-multiply: FSM returns to IDLE and no result is written.
- Non-mul ops while the FSM is IDLE never touch it.

## Timing
- Non-mul op: one cycle in E. The result appears on the M outputs the cycle after E.
- mul issued in E at cycle 0:
  - MulBusyE is high in cycles 0–32 and low in cycle 33 (DONE).
  - The result is registered at the end of cycle 33 and visible on ALUResultM in cycle 34.
  - Bubbles enter M at the ends of cycles 0–32.
- Upstream holds ALUControlE, the operands and the rd fields stable while MulBusyE = 1. The stage depends only on the latched operands after issue.
- Reset values: ALUResultM = 0, WriteDataM = 0, RegDestinM = 0, RegWriteM = 0, FSM = IDLE, MulBusyE = 0 unless a mul op is presented.

## Configuration
- EXEC_MUL_EN defined: the multiplier FSM is built, and ALUControlE = 1010 behaves as above.
- EXEC_MUL_EN undefined: no FSM is built. MulBusyE is tied to 0, and code 1010 gives result 0 in one cycle like any other unused code.

## Test plan
- Reset, then ALUControlE = 0000, RD1E = 5, RD2E = 7, ALUSrcE = 0, RegDestinE = 3, RegWriteE = 1 → next cycle ALUResultM = 12, RegDestinM = 3, RegWriteM = 1.
- Forwarding: RD1E = 1, ALUResultM = 100 (from a prior add), ForwardAE = 10, ImmExtE = 4, ALUSrcE = 1 → ALUResultM = 104. Then ForwardAE = 01 with ResultW = 9 → 13. ForwardAE = 11 → uses RD1E.
- sub 3−5 → 0xFFFFFFFE. slt(−1, 1) = 1. sltu(0xFFFFFFFF, 1) = 0. sra(0x80000000, 4) = 0xF8000000. Equal operands on sub → ZeroE = 1. PCE = 0x100, ImmExtE = −8 → PCTargetE = 0xF8.
- EXEC_MUL_EN: mul 0x12345678 × 0x10 → MulBusyE high for exactly 33 cycles, RegWriteM = 0 throughout, ALUResultM = 0x23456780 in cycle 34. Also check 0xFFFFFFFF × 0xFFFFFFFF → 1.
- FlushE asserted in cycle 10 of a mul → next cycle FSM is IDLE, MulBusyE = 0 once ALUControlE changes, and no write reaches M. Repeat with reset in cycle 20, with the same outcome.
- EXEC_MUL_EN undefined: ALUControlE = 1010 → MulBusyE stays 0 and ALUResultM = 0 after one cycle.
